risc5_int_unit: RTL and testbench

//  Parametrised interrupt unit for the RISC5 core. Replaces the CPU's single-irq logic
//  (irq1/intPnd/intEnb/intMd/SPC) with NUM_IRQ prioritised edge-triggered channels.

---
 rtl/risc5_int_pkg.sv | 6 +
 rtl/risc5_int_prio.sv | 25 ++
 rtl/risc5_int_unit.sv | 115 +++++++++++
 tb/tb_risc5_int_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc5_int_pkg.sv
// Shared widths for the RISC5 interrupt unit and its priority encoder.
package risc5_int_pkg;
   localparam int LEVEL_W = 6;
   localparam int DEPTH_W = 5;
   localparam int FLAGS_W = 4;
endpackage

// File: rtl/risc5_int_prio.sv
// Lowest-index-wins priority encoder over the enabled pending requests.
// Purely combinational, zero latency; no flow control.
module risc5_int_prio
   import risc5_int_pkg::*;
#(
   parameter int NUM_IRQ = 8
) (
   input  logic [NUM_IRQ-1:0] req,
   output logic               valid,
   output logic [LEVEL_W-1:0] idx
);

   // Scanning downwards lets the lowest set index overwrite the others.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            valid = 1'b1;
            idx   = LEVEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/risc5_int_unit.sv
// Prioritised, nesting interrupt unit for the RISC5 core with a {flags, PC, level} save stack.
// int_ack is combinational in the cycle a candidate wins; stall, rti or a full stack hold it off.
module risc5_int_unit
   import risc5_int_pkg::*;
#(
   parameter int NUM_IRQ     = 8,
   parameter int STACK_DEPTH = 4,
   parameter int PC_W        = 22,
   parameter int ISR_BASE    = 1,
   parameter int VEC_STRIDE  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               mask_wr,
   input  logic [NUM_IRQ-1:0] mask_din,
   input  logic               ien_wr,
   input  logic               ien_val,
   input  logic               stall,
   input  logic               rti,
   input  logic [PC_W-1:0]    pc_next,
   input  logic [FLAGS_W-1:0] flags_next,
   input  logic               intabort,
   output logic               int_ack,
   output logic [PC_W-1:0]    isr_adr,
   output logic [PC_W-1:0]    ret_pc,
   output logic [FLAGS_W-1:0] ret_flags,
   output logic [NUM_IRQ-1:0] pending,
   output logic [LEVEL_W-1:0] cur_level,
   output logic [DEPTH_W-1:0] depth,
   output logic               rti_err
);

   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int SLOTS = 1 << IDX_W;

   typedef struct packed {
      logic [FLAGS_W-1:0] flags;
      logic [PC_W-1:0]    pc;
      logic [LEVEL_W-1:0] level;
   } ctx_t;

   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] pend_nxt;
   logic               ien;
   ctx_t               stack [SLOTS];
   ctx_t               top_ctx;
   logic               cand_valid;
   logic [LEVEL_W-1:0] cand;
   logic [IDX_W-1:0]   top_idx;
   logic [IDX_W-1:0]   push_idx;
   logic               stack_nonempty;

   risc5_int_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
      .req   (pending & mask),
      .valid (cand_valid),
      .idx   (cand)
   );

   assign stack_nonempty = (depth != '0);
   assign top_idx        = IDX_W'(depth - DEPTH_W'(1));
   assign push_idx       = IDX_W'(depth);
   assign top_ctx        = stack[top_idx];

   assign int_ack = ien & ~stall & ~rti & cand_valid & (cand < cur_level)
                  & (depth < DEPTH_W'(STACK_DEPTH));
   assign isr_adr   = PC_W'(ISR_BASE) + PC_W'(cand) * PC_W'(VEC_STRIDE);
   assign ret_pc    = stack_nonempty ? top_ctx.pc    : '0;
   assign ret_flags = stack_nonempty ? top_ctx.flags : '0;

   // A fresh edge on the channel being acked must survive the clear.
   always_comb begin
      pend_nxt = pending;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (int_ack && cand == LEVEL_W'(i)) pend_nxt[i] = 1'b0;
      end
      pend_nxt = pend_nxt | (irq & ~irq_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q     <= '0;
         pending   <= '0;
         mask      <= '1;
         ien       <= 1'b0;
         depth     <= '0;
         cur_level <= LEVEL_W'(NUM_IRQ);
         rti_err   <= 1'b0;
         for (int i = 0; i < SLOTS; i++) stack[i] <= '0;
      end else begin
         irq_q   <= irq;
         pending <= pend_nxt;
         if (mask_wr) mask <= mask_din;
         if (ien_wr)  ien  <= ien_val;

         if (int_ack) begin
            stack[push_idx] <= '{flags: flags_next, pc: pc_next, level: cur_level};
            cur_level       <= cand;
            depth           <= depth + DEPTH_W'(1);
         end else if (rti) begin
            if (stack_nonempty) begin
               cur_level <= top_ctx.level;
               depth     <= depth - DEPTH_W'(1);
            end else begin
               rti_err <= 1'b1;
            end
         end else if (intabort && stack_nonempty) begin
            stack[top_idx].pc    <= '0;
            stack[top_idx].flags <= '0;
         end
      end
   end

endmodule

// File: tb/tb_risc5_int_unit.sv
// Directed self-checking bench for risc5_int_unit; acks are scored against a queue of expected channels.
module tb_risc5_int_unit;
   localparam int NUM_IRQ = 8;
   localparam int SD      = 2;
   localparam int PC_W    = 22;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_IRQ-1:0] irq;
   logic               mask_wr;
   logic [NUM_IRQ-1:0] mask_din;
   logic               ien_wr;
   logic               ien_val;
   logic               stall;
   logic               rti;
   logic [PC_W-1:0]    pc_next;
   logic [3:0]         flags_next;
   logic               intabort;
   logic               int_ack;
   logic [PC_W-1:0]    isr_adr;
   logic [PC_W-1:0]    ret_pc;
   logic [3:0]         ret_flags;
   logic [NUM_IRQ-1:0] pending;
   logic [5:0]         cur_level;
   logic [4:0]         depth;
   logic               rti_err;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   risc5_int_unit #(.NUM_IRQ(NUM_IRQ), .STACK_DEPTH(SD), .PC_W(PC_W),
                    .ISR_BASE(1), .VEC_STRIDE(2)) dut (
      .clk(clk), .rst(rst), .irq(irq), .mask_wr(mask_wr), .mask_din(mask_din),
      .ien_wr(ien_wr), .ien_val(ien_val), .stall(stall), .rti(rti),
      .pc_next(pc_next), .flags_next(flags_next), .intabort(intabort),
      .int_ack(int_ack), .isr_adr(isr_adr), .ret_pc(ret_pc), .ret_flags(ret_flags),
      .pending(pending), .cur_level(cur_level), .depth(depth), .rti_err(rti_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int ch);
      irq[ch] = 1'b1;
      tick();
      irq[ch] = 1'b0;
      #1;
   endtask

   task automatic expect_ack(input int ch);
      exp_q.push_back(ch);
   endtask

   // Scoreboard: every ack must match the oldest expected channel's vector.
   always @(negedge clk) begin
      if (rst === 1'b0 && int_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_ack: observed isr_adr %0h expected no ack", isr_adr);
         end else begin
            int ch;
            ch = exp_q.pop_front();
            chk("ack_isr_adr", 32'(isr_adr), 32'(1 + ch * 2));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; irq = '0; mask_wr = 1'b0; mask_din = '0; ien_wr = 1'b0; ien_val = 1'b0;
      stall = 1'b0; rti = 1'b0; pc_next = '0; flags_next = '0; intabort = 1'b0;
      #12 rst = 1'b0;
      #1;
      chk("rst_pending", 32'(pending), 0);
      chk("rst_depth", 32'(depth), 0);
      chk("rst_level", 32'(cur_level), 8);
      chk("rst_ret_pc", 32'(ret_pc), 0);
      chk("rst_rti_err", 32'(rti_err), 0);
      chk("rst_ack", 32'(int_ack), 0);
      tick();
      ien_wr = 1'b1; ien_val = 1'b1;
      tick();
      ien_wr = 1'b0;

      // Single interrupt on channel 3
      pc_next = 22'h100; flags_next = 4'ha;
      expect_ack(3);
      pulse(3);
      chk("t1_pending", 32'(pending), 32'h08);
      chk("t1_ack", 32'(int_ack), 1);
      tick();
      chk("t1_depth", 32'(depth), 1);
      chk("t1_level", 32'(cur_level), 3);
      chk("t1_ret_pc", 32'(ret_pc), 32'h100);
      chk("t1_ret_flags", 32'(ret_flags), 32'ha);
      chk("t1_pend_clr", 32'(pending), 0);

      // Lower priority waits, higher priority nests
      pulse(5);
      chk("t2_pend5", 32'(pending), 32'h20);
      chk("t2_no_ack5", 32'(int_ack), 0);
      pc_next = 22'h200; flags_next = 4'h5;
      expect_ack(1);
      pulse(1);
      tick();
      chk("t2_depth2", 32'(depth), 2);
      chk("t2_level1", 32'(cur_level), 1);
      chk("t2_ret_pc", 32'(ret_pc), 32'h200);
      chk("t2_pend", 32'(pending), 32'h20);
      rti = 1'b1; #1;
      chk("t2_rti_ret_pc", 32'(ret_pc), 32'h200);
      tick();
      rti = 1'b0; #1;
      chk("t2_level3", 32'(cur_level), 3);
      chk("t2_depth1", 32'(depth), 1);
      chk("t2_ret_pc1", 32'(ret_pc), 32'h100);
      rti = 1'b1;
      tick();
      chk("t2_level8", 32'(cur_level), 8);
      chk("t2_depth0", 32'(depth), 0);
      pc_next = 22'h300;
      expect_ack(5);
      rti = 1'b0; #1;
      chk("t2_ack5", 32'(int_ack), 1);
      tick();
      chk("t2_level5", 32'(cur_level), 5);
      chk("t2_ret_pc5", 32'(ret_pc), 32'h300);
      rti = 1'b1;
      tick();
      rti = 1'b0; #1;
      chk("t2_final_depth", 32'(depth), 0);
      chk("t2_final_level", 32'(cur_level), 8);

      // rti at depth 0 with a candidate present
      pc_next = 22'h1234; flags_next = 4'hf;
      irq[6] = 1'b1;
      tick();
      irq[6] = 1'b0; rti = 1'b1; #1;
      chk("t4_rti_wins", 32'(int_ack), 0);
      expect_ack(6);
      tick();
      rti = 1'b0; #1;
      chk("t4_rti_err", 32'(rti_err), 1);
      chk("t4_depth0", 32'(depth), 0);
      chk("t4_ack_after", 32'(int_ack), 1);
      tick();
      chk("t4_depth1", 32'(depth), 1);
      chk("t5_saved_pc", 32'(ret_pc), 32'h1234);

      // intabort clears the top context
      intabort = 1'b1;
      tick();
      intabort = 1'b0; #1;
      chk("t5_abort_pc", 32'(ret_pc), 0);
      chk("t5_abort_flags", 32'(ret_flags), 0);
      chk("t5_abort_level", 32'(cur_level), 6);
      rti = 1'b1;
      tick();
      rti = 1'b0;

      // Masked channel latches but is not taken until unmasked
      mask_wr = 1'b1; mask_din = 8'hfb;
      tick();
      mask_wr = 1'b0;
      pulse(2);
      chk("t5_masked_pend", 32'(pending), 32'h04);
      chk("t5_masked_ack", 32'(int_ack), 0);
      tick();
      chk("t5_masked_ack2", 32'(int_ack), 0);
      expect_ack(2);
      mask_wr = 1'b1; mask_din = 8'hff;
      tick();
      mask_wr = 1'b0; #1;
      chk("t5_unmask_ack", 32'(int_ack), 1);
      tick();
      chk("t5_level2", 32'(cur_level), 2);
      rti = 1'b1;
      tick();
      rti = 1'b0;

      // Stack full blocks further nesting
      pc_next = 22'h700;
      expect_ack(7);
      pulse(7);
      tick();
      expect_ack(4);
      pulse(4);
      tick();
      chk("t3_depth_full", 32'(depth), 2);
      chk("t3_level4", 32'(cur_level), 4);
      pulse(0);
      chk("t3_full_pend", 32'(pending), 32'h01);
      chk("t3_full_no_ack", 32'(int_ack), 0);
      tick();
      chk("t3_full_no_ack2", 32'(int_ack), 0);
      expect_ack(0);
      rti = 1'b1; #1;
      chk("t3_rti_no_ack", 32'(int_ack), 0);
      tick();
      rti = 1'b0; #1;
      chk("t3_ack0", 32'(int_ack), 1);
      chk("t3_depth_pop", 32'(depth), 1);
      chk("t3_level7", 32'(cur_level), 7);
      tick();
      chk("t3_level0", 32'(cur_level), 0);
      rti = 1'b1;
      tick();
      tick();
      rti = 1'b0; #1;
      chk("t3_unwound", 32'(depth), 0);

      // Stall blocks ack; reset mid-nesting
      stall = 1'b1;
      pulse(3);
      chk("t6_stall_no_ack", 32'(int_ack), 0);
      expect_ack(3);
      stall = 1'b0; #1;
      chk("t6_unstall_ack", 32'(int_ack), 1);
      tick();
      expect_ack(1);
      pulse(1);
      tick();
      chk("t6_depth2", 32'(depth), 2);
      irq[5] = 1'b1;
      tick();
      irq = '0; rst = 1'b1; #1;
      chk("t6_rst_pending", 32'(pending), 0);
      chk("t6_rst_depth", 32'(depth), 0);
      chk("t6_rst_level", 32'(cur_level), 8);
      chk("t6_rst_ret_pc", 32'(ret_pc), 0);
      chk("t6_rst_rti_err", 32'(rti_err), 0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_post_rst_ack", 32'(int_ack), 0);
      chk("sb_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
